// File: rtl/chirp_phase_gen.sv
// Frame-based FMCW chirp sequencer: linear frequency ramp integrated into a phase word,
// NUM_CHIRPS phase-coherent chirps per frame separated by idle gaps.
//
// state  | meaning
// IDLE   | waiting for start, outputs at rest
// RAMP   | emitting live ramp samples, sample counter counts down to 0
// GAP    | idle gap between chirps, gap counter counts down to 0
module chirp_phase_gen #(
    parameter int PHASE_WIDTH = 22,
    parameter int RAMP_LEN    = 256,
    parameter int GAP_LEN     = 32,
    parameter int NUM_CHIRPS  = 16,
    localparam int IDX_W      = (NUM_CHIRPS > 1) ? $clog2(NUM_CHIRPS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PHASE_WIDTH-1:0] f_start,
    input  logic [PHASE_WIDTH-1:0] f_slope,
    output logic [PHASE_WIDTH-1:0] phase,
    output logic                   phase_valid,
    output logic                   chirp_start,
    output logic [IDX_W-1:0]       chirp_idx,
    output logic                   busy,
    output logic                   frame_done
);

    localparam int SW = $clog2(RAMP_LEN);
    localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [SW-1:0]    SAMP_FIRST = SW'(RAMP_LEN - 1);
    localparam logic [GW-1:0]    GAP_FIRST  = GW'(GAP_LEN - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_CHIRPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RAMP = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [SW-1:0]          samp_cnt, samp_nxt;
    logic [GW-1:0]          gap_cnt, gap_nxt;
    logic [PHASE_WIDTH-1:0] phase_r, phase_nxt;
    logic [PHASE_WIDTH-1:0] freq_r, freq_nxt;
    logic [PHASE_WIDTH-1:0] fs_r, fs_nxt;
    logic [PHASE_WIDTH-1:0] sl_r, sl_nxt;
    logic [IDX_W-1:0]       idx_r, idx_nxt;
    logic                   done_r, done_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            samp_cnt <= '0;
            gap_cnt  <= '0;
            phase_r  <= '0;
            freq_r   <= '0;
            fs_r     <= '0;
            sl_r     <= '0;
            idx_r    <= '0;
            done_r   <= 1'b0;
        end else begin
            samp_cnt <= samp_nxt;
            gap_cnt  <= gap_nxt;
            phase_r  <= phase_nxt;
            freq_r   <= freq_nxt;
            fs_r     <= fs_nxt;
            sl_r     <= sl_nxt;
            idx_r    <= idx_nxt;
            done_r   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        samp_nxt  = samp_cnt;
        gap_nxt   = gap_cnt;
        phase_nxt = phase_r;
        freq_nxt  = freq_r;
        fs_nxt    = fs_r;
        sl_nxt    = sl_r;
        idx_nxt   = idx_r;
        done_nxt  = 1'b0;

        if (abort) begin
            state_nxt = S_IDLE;
            samp_nxt  = '0;
            gap_nxt   = '0;
            phase_nxt = '0;
            freq_nxt  = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nxt = S_RAMP;
                        samp_nxt  = SAMP_FIRST;
                        phase_nxt = '0;
                        freq_nxt  = f_start;
                        fs_nxt    = f_start;
                        sl_nxt    = f_slope;
                        idx_nxt   = '0;
                    end
                end
                S_RAMP: begin
                    if (samp_cnt == '0) begin
                        // phase and freq park at 0 so the phase output rests outside the ramp
                        phase_nxt = '0;
                        freq_nxt  = '0;
                        if (idx_r == IDX_LAST) begin
                            state_nxt = S_IDLE;
                            idx_nxt   = '0;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = S_GAP;
                            gap_nxt   = GAP_FIRST;
                        end
                    end else begin
                        samp_nxt  = samp_cnt - SW'(1);
                        phase_nxt = phase_r + freq_r;
                        freq_nxt  = freq_r + sl_r;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) begin
                        state_nxt = S_RAMP;
                        samp_nxt  = SAMP_FIRST;
                        phase_nxt = '0;
                        freq_nxt  = fs_r;
                        idx_nxt   = idx_r + IDX_W'(1);
                    end else begin
                        gap_nxt = gap_cnt - GW'(1);
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign phase       = phase_r;
    assign phase_valid = (state == S_RAMP);
    assign chirp_start = (state == S_RAMP) && (samp_cnt == SAMP_FIRST);
    assign chirp_idx   = idx_r;
    assign busy        = (state != S_IDLE);
    assign frame_done  = done_r;

endmodule

// File: tb/tb_chirp_phase_gen.sv
// Self-checking bench for chirp_phase_gen: randomized frames compared against a closed-form
// ramp model, plus directed abort, reset, wrap and back-to-back scenarios.
module tb_chirp_phase_gen;

    localparam int PW = 22;
    localparam int RL = 8;
    localparam int GL = 2;
    localparam int NC = 3;
    localparam int IW = 2;
    localparam int VW = PW + IW + 4;
    localparam int FL = NC * RL + (NC - 1) * GL;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [PW-1:0] f_start;
    logic [PW-1:0] f_slope;
    logic [PW-1:0] phase;
    logic          phase_valid;
    logic          chirp_start;
    logic [IW-1:0] chirp_idx;
    logic          busy;
    logic          frame_done;

    int total = 0;
    int bad   = 0;

    logic [VW-1:0] obs;
    logic [VW-1:0] expv;
    logic [VW-1:0] done_vec;
    logic [VW-1:0] zero_vec;

    chirp_phase_gen #(
        .PHASE_WIDTH(PW),
        .RAMP_LEN   (RL),
        .GAP_LEN    (GL),
        .NUM_CHIRPS (NC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .f_start    (f_start),
        .f_slope    (f_slope),
        .phase      (phase),
        .phase_valid(phase_valid),
        .chirp_start(chirp_start),
        .chirp_idx  (chirp_idx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    assign obs = {phase, phase_valid, chirp_start, chirp_idx, busy, frame_done};

    // phase_k = sum_{j<k} (fs + j*sl) = k*fs + sl*k*(k-1)/2
    function automatic logic [PW-1:0] ramp_phase(input logic [PW-1:0] fs, input logic [PW-1:0] sl,
                                                 input int k);
        longint kk;
        longint acc;
        kk  = longint'(k);
        acc = kk * longint'(fs) + longint'(sl) * ((kk * (kk - 1)) / 2);
        return acc[PW-1:0];
    endfunction

    // expected outputs n cycles after the start edge within one frame
    function automatic logic [VW-1:0] frame_vec(input logic [PW-1:0] fs, input logic [PW-1:0] sl,
                                                input int n);
        int c;
        int r;
        logic [IW-1:0] idx;
        c   = n / (RL + GL);
        r   = n % (RL + GL);
        idx = IW'(c);
        if (r < RL)
            return {ramp_phase(fs, sl, r), 1'b1, (r == 0), idx, 1'b1, 1'b0};
        else
            return {{PW{1'b0}}, 1'b0, 1'b0, idx, 1'b1, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame; leaves time at the frame_done cycle with start low.
    task automatic run_frame(input logic [PW-1:0] fs, input logic [PW-1:0] sl, input string name);
        f_start = fs;
        f_slope = sl;
        start   = 1'b1;
        tick();
        for (int n = 0; n < FL; n++) begin
            expv = frame_vec(fs, sl, n);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", name, n, obs, expv);
            end
            start   = ($urandom_range(0, 3) == 0);
            f_start = PW'($urandom);
            f_slope = PW'($urandom);
            tick();
        end
        total++;
        if (obs !== done_vec) begin
            bad++;
            $display("FAIL %s_done got=%h exp=%h", name, obs, done_vec);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        abort = 1'b0;
        f_start = 22'd5;
        f_slope = 22'd7;
        tick();
        tick();
        total++;
        if (obs !== zero_vec) begin
            bad++;
            $display("FAIL reset got=%h exp=%h", obs, zero_vec);
        end
        start = 1'b0;
        reset = 1'b0;
        tick();
        total++;
        if (obs !== zero_vec) begin
            bad++;
            $display("FAIL idle_hold got=%h exp=%h", obs, zero_vec);
        end
    endtask

    task automatic test_constant();
        run_frame(22'd100, 22'd0, "const");
        tick();
        total++;
        if (obs !== zero_vec) begin
            bad++;
            $display("FAIL after_done got=%h exp=%h", obs, zero_vec);
        end
    endtask

    task automatic test_slope_table();
        int tbl [RL];
        tbl = '{0, 100, 210, 330, 460, 600, 750, 910};
        f_start = 22'd100;
        f_slope = 22'd10;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < RL; k++) begin
            total++;
            if (phase !== PW'(tbl[k]) || phase_valid !== 1'b1) begin
                bad++;
                $display("FAIL slope_tbl k=%0d got=%0d/%b exp=%0d/1", k, phase, phase_valid, tbl[k]);
            end
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_wrap();
        run_frame(22'h3FFFFF, 22'd1, "wrap");
        tick();
    endtask

    task automatic test_random_frames();
        for (int i = 0; i < 4; i++) begin
            run_frame(PW'($urandom), PW'($urandom), "rand");
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] fs;
        logic [PW-1:0] sl;
        for (int i = 0; i < 3; i++) begin
            fs = PW'($urandom);
            sl = PW'($urandom);
            run_frame(fs, sl, "b2b");
        end
        tick();
    endtask

    task automatic test_abort();
        logic [PW-1:0] fs;
        logic [PW-1:0] sl;
        fs = PW'($urandom);
        sl = PW'($urandom);
        f_start = fs;
        f_slope = sl;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        total++;
        if (obs !== frame_vec(fs, sl, 3)) begin
            bad++;
            $display("FAIL abort_pre got=%h exp=%h", obs, frame_vec(fs, sl, 3));
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        total++;
        if (obs !== zero_vec) begin
            bad++;
            $display("FAIL abort_ramp got=%h exp=%h", obs, zero_vec);
        end
        f_start = 22'd42;
        start   = 1'b1;
        tick();
        start = 1'b0;
        expv = frame_vec(22'd42, 22'd0, 0);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL abort_restart got=%h exp=%h", obs, expv);
        end
        repeat (RL) tick();
        expv = frame_vec(22'd42, 22'd0, RL);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL gap_state got=%h exp=%h", obs, expv);
        end
        abort = 1'b1;
        start = 1'b1;
        tick();
        total++;
        if (obs !== zero_vec) begin
            bad++;
            $display("FAIL abort_gap got=%h exp=%h", obs, zero_vec);
        end
        tick();
        total++;
        if (obs !== zero_vec) begin
            bad++;
            $display("FAIL abort_start_idle got=%h exp=%h", obs, zero_vec);
        end
        abort   = 1'b0;
        f_start = 22'd9;
        f_slope = 22'd3;
        tick();
        start = 1'b0;
        expv = frame_vec(22'd9, 22'd3, 0);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL start_after_abort got=%h exp=%h", obs, expv);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [PW-1:0] fs;
        logic [PW-1:0] sl;
        fs = PW'($urandom);
        sl = PW'($urandom);
        f_start = fs;
        f_slope = sl;
        start   = 1'b1;
        tick();
        start = 1'b0;
        repeat (RL + 1) tick();
        reset = 1'b1;
        tick();
        total++;
        if (obs !== zero_vec) begin
            bad++;
            $display("FAIL reset_mid got=%h exp=%h", obs, zero_vec);
        end
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < FL; n++) begin
            expv = frame_vec(fs, sl, n);
            total++;
            if (obs !== expv) begin
                bad++;
                $display("FAIL reset_restart cyc=%0d got=%h exp=%h", n, obs, expv);
            end
            tick();
        end
        total++;
        if (obs !== done_vec) begin
            bad++;
            $display("FAIL reset_restart_done got=%h exp=%h", obs, done_vec);
        end
        tick();
    endtask

    initial begin
        zero_vec = '0;
        done_vec = {{(VW-1){1'b0}}, 1'b1};
        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        f_start  = '0;
        f_slope  = '0;
        test_reset();
        test_constant();
        test_slope_table();
        test_wrap();
        test_random_frames();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
